// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipe while busy and pulses done with a registered result.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REM  = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] rem_q,    rem_d;
    logic [WIDTH-1:0] quo_q,    quo_d;
    logic [WIDTH-1:0] dvs_q,    dvs_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             quot_q,   quot_d;
    logic             qneg_q,   qneg_d;
    logic             rneg_q,   rneg_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             op_ok;
    logic             is_signed;
    logic             is_quot;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             special;
    logic [WIDTH-1:0] special_res;
    logic             accept;
    logic [WIDTH:0]   rem_ext;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] fin_res;

    always_comb begin
        op_ok     = (alu_control == OP_DIV)  || (alu_control == OP_DIVU) ||
                    (alu_control == OP_REM)  || (alu_control == OP_REMU);
        is_signed = (alu_control == OP_DIV)  || (alu_control == OP_REM);
        is_quot   = (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        special     = 1'b0;
        special_res = '0;
        if (b == '0) begin
            special     = 1'b1;
            special_res = is_quot ? '1 : a;
        end else if (is_signed && (a == MIN_NEG) && (b == '1)) begin
            special     = 1'b1;
            special_res = is_quot ? MIN_NEG : '0;
        end

        accept = start & ~kill & (state_q != S_CALC) & op_ok;

        // Shifted partial remainder needs one extra bit when divisor > 2^(W-1).
        rem_ext = {rem_q, quo_q[WIDTH-1]};
        trial   = rem_ext - {1'b0, dvs_q};
        ge      = ~trial[WIDTH];
        rem_n   = ge ? trial[WIDTH-1:0] : rem_ext[WIDTH-1:0];
        quo_n   = {quo_q[WIDTH-2:0], ge};
        fin_res = quot_q ? (qneg_q ? -quo_n : quo_n)
                         : (rneg_q ? -rem_n : rem_n);
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        if (kill) begin
            state_d = S_IDLE;
        end else if (state_q == S_CALC) begin
            rem_d = rem_n;
            quo_d = quo_n;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                result_d = fin_res;
                state_d  = S_DONE;
            end
        end else if (accept) begin
            rem_d  = '0;
            quo_d  = a_mag;
            dvs_d  = b_mag;
            cnt_d  = CNT_INIT;
            quot_d = is_quot;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            if (special) begin
                result_d = special_res;
                state_d  = S_DONE;
            end else begin
                state_d  = S_CALC;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            quot_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, expected results
// queued at issue time and popped by a monitor on each done pulse.
module tb_div_unit;

    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REM  = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    string       nm[$];
    string       mon_n;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .kill       (kill),
        .alu_control(alu_control),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got %h want no done", result);
            end else begin
                mon_n = nm.pop_front();
                check(mon_n, result, sb.pop_front());
                check({mon_n, "_busy_at_done"}, {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic expect_res(input string name, input logic [31:0] exp);
        nm.push_back(name);
        sb.push_back(exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] aa,
                         input logic [31:0] bb);
        alu_control = op;
        a           = aa;
        b           = bb;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int nb;
        int n;
        nb = 0;
        n  = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) nb++;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout got no done want done", name);
                return;
            end
        end
        check({name, "_busy_cycles"}, nb, exp_busy);
        check({name, "_latency"}, n, exp_busy);
    endtask

    task automatic run(input string name, input logic [3:0] op,
                       input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] exp, input int exp_busy);
        @(negedge clk);
        expect_res(name, exp);
        issue(op, aa, bb);
        wait_done(name, exp_busy);
    endtask

    initial begin
        int bad;
        reset       = 1'b1;
        start       = 1'b0;
        kill        = 1'b0;
        alu_control = 4'b0000;
        a           = '0;
        b           = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);

        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32);
        run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 32);
        run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);
        run("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32);
        run("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32);
        run("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run("remu_1234_0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 0);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 0);
        run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        // back-to-back with inputs disturbed and a stray start mid-CALC
        @(negedge clk);
        expect_res("b2b_first", 32'd14);
        issue(OP_DIVU, 32'd100, 32'd7);
        fork
            begin
                repeat (3) @(negedge clk);
                a     = 32'd50;
                b     = 32'd5;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                a     = 32'hDEAD_BEEF;
                b     = 32'd3;
            end
        join_none
        wait_done("b2b_first", 32);
        expect_res("b2b_second", 32'd3);
        issue(OP_DIVU, 32'd9, 32'd3);
        @(negedge clk);
        check("b2b_no_gap", {31'b0, busy}, 32'd1);
        wait_done("b2b_second", 31);

        // kill mid-CALC
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_done", {31'b0, done}, 32'd0);
        check("kill_result", result, 32'd3);
        repeat (40) @(negedge clk);

        // kill wins over start on the same edge
        @(negedge clk);
        kill = 1'b1;
        issue(OP_DIVU, 32'd10, 32'd2);
        kill = 1'b0;
        @(negedge clk);
        check("kill_over_start", {30'b0, busy, done}, 32'd0);

        // unsupported op code is ignored
        @(negedge clk);
        issue(4'b0010, 32'd10, 32'd2);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        check("bad_op_idle", bad, 32'd0);

        // asynchronous reset mid-CALC
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("areset_busy", {31'b0, busy}, 32'd0);
        check("areset_done", {31'b0, done}, 32'd0);
        check("areset_result", result, 32'd0);
        #1 reset = 1'b0;

        run("post_reset", OP_DIVU, 32'd9, 32'd3, 32'd3, 32);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
